// File: rtl/mvm_config_loader.sv
// -----------------------------------------------------------------------------
// mvm_config_loader
//
// Single NoC injection point for MVM configuration traffic. Instruction words
// and weight-RF rows come from two requesters. The block arbitrates between
// them round-robin, one whole packet at a time, and drives one AXI-S mesh port.
// Every flit is formatted as {tuser, data}.
//
// Optional feature macro: MVM_LOADER_STATS_EN
//   defined   -> inst_count, wgt_count and addr_ovf are live registers
//   undefined -> those three outputs are tied to 0 and no registers are built
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   inst_valid/ready/data/dest/last
//                             : instruction requester (32-bit words)
//   wgt_valid/ready/data/dpe/dest/last
//                             : weight requester (DATAW-bit rows, DPE index)
//   axis_tx_tvalid/tready/tdata/tid/tdest/tlast
//                             : NoC output; tid 0 = instruction, 1 = weight
//   busy                      : FSM not idle, or a flit is held at the output
//   addr_ovf                  : sticky, weight RF address wrapped inside a packet
//   inst_count, wgt_count     : saturating counts of accepted flits
// -----------------------------------------------------------------------------
module mvm_config_loader #(
    parameter int DATAW = 512,
    parameter int USERW = 75,
    parameter int DESTW = 4,
    parameter int IDW   = 2,
    parameter int DPES  = 64,
    parameter int ADDRW = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [31:0]              inst_data,
    input  logic [DESTW-1:0]         inst_dest,
    input  logic                     inst_last,

    input  logic                     wgt_valid,
    output logic                     wgt_ready,
    input  logic [DATAW-1:0]         wgt_data,
    input  logic [$clog2(DPES)-1:0]  wgt_dpe,
    input  logic [DESTW-1:0]         wgt_dest,
    input  logic                     wgt_last,

    output logic                     axis_tx_tvalid,
    input  logic                     axis_tx_tready,
    output logic [DATAW+USERW-1:0]   axis_tx_tdata,
    output logic [IDW-1:0]           axis_tx_tid,
    output logic [DESTW-1:0]         axis_tx_tdest,
    output logic                     axis_tx_tlast,

    output logic                     busy,
    output logic                     addr_ovf,
    output logic [15:0]              inst_count,
    output logic [15:0]              wgt_count
);

    localparam int FLITW = DATAW + USERW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INST = 2'd1,
        S_WGT  = 2'd2
    } state_t;

    // rr_last: 1 = weight requester was served last, 0 = instruction.
    state_t              state_q,     state_d;
    logic                rr_last_q,   rr_last_d;
    logic [ADDRW-1:0]    waddr_q,     waddr_d;

    logic                out_valid_q, out_valid_d;
    logic [FLITW-1:0]    out_data_q,  out_data_d;
    logic [IDW-1:0]      out_tid_q,   out_tid_d;
    logic [DESTW-1:0]    out_dest_q,  out_dest_d;
    logic                out_last_q,  out_last_d;

    logic                out_can_load;
    logic                inst_rdy_c;
    logic                wgt_rdy_c;
    logic                inst_acc;
    logic                wgt_acc;
    logic [DPES-1:0]     wgt_onehot;
    logic [USERW-1:0]    wgt_user;

    // -------------------------------------------------------------------------
    // Arbitration FSM, weight address and output register next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        waddr_d     = waddr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tid_d   = out_tid_q;
        out_dest_d  = out_dest_q;
        out_last_d  = out_last_q;

        // The single output slot can take a new flit when it is empty or
        // its current flit leaves this cycle.
        out_can_load = !out_valid_q || axis_tx_tready;
        inst_rdy_c   = (state_q == S_INST) && out_can_load;
        wgt_rdy_c    = (state_q == S_WGT)  && out_can_load;
        inst_acc     = inst_valid && inst_rdy_c;
        wgt_acc      = wgt_valid  && wgt_rdy_c;

        wgt_onehot          = '0;
        wgt_onehot[wgt_dpe] = 1'b1;
        wgt_user                 = '0;
        wgt_user[ADDRW-1:0]      = waddr_q;
        wgt_user[10:9]           = 2'b11;
        wgt_user[USERW-1:11]     = wgt_onehot;

        unique case (state_q)
            S_IDLE: begin
                // With both requesting, the one not served last wins.
                if (inst_valid && (!wgt_valid || rr_last_q)) begin
                    state_d = S_INST;
                end else if (wgt_valid) begin
                    state_d = S_WGT;
                    waddr_d = '0;
                end
            end
            S_INST: begin
                if (inst_acc && inst_last) begin
                    state_d   = S_IDLE;
                    rr_last_d = 1'b0;
                end
            end
            S_WGT: begin
                if (wgt_acc) begin
                    // Natural wrap at 2^ADDRW.
                    waddr_d = waddr_q + ADDRW'(1);
                end
                if (wgt_acc && wgt_last) begin
                    state_d   = S_IDLE;
                    rr_last_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (inst_acc) begin
            out_valid_d       = 1'b1;
            out_data_d        = '0;
            out_data_d[31:0]  = inst_data;
            out_tid_d         = IDW'(0);
            out_dest_d        = inst_dest;
            out_last_d        = inst_last;
        end else if (wgt_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = {wgt_user, wgt_data};
            out_tid_d   = IDW'(1);
            out_dest_d  = wgt_dest;
            out_last_d  = wgt_last;
        end else if (axis_tx_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_last_q   <= 1'b1;
            waddr_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tid_q   <= '0;
            out_dest_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            waddr_q     <= waddr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tid_q   <= out_tid_d;
            out_dest_q  <= out_dest_d;
            out_last_q  <= out_last_d;
        end
    end

    assign inst_ready     = inst_rdy_c;
    assign wgt_ready      = wgt_rdy_c;
    assign axis_tx_tvalid = out_valid_q;
    assign axis_tx_tdata  = out_data_q;
    assign axis_tx_tid    = out_tid_q;
    assign axis_tx_tdest  = out_dest_q;
    assign axis_tx_tlast  = out_last_q;
    assign busy           = (state_q != S_IDLE) || out_valid_q;

`ifdef MVM_LOADER_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: saturating flit counters and sticky address-wrap flag
    // -------------------------------------------------------------------------
    logic [15:0] inst_cnt_q, inst_cnt_d;
    logic [15:0] wgt_cnt_q,  wgt_cnt_d;
    logic        addr_ovf_q, addr_ovf_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        inst_cnt_d = inst_cnt_q;
        wgt_cnt_d  = wgt_cnt_q;
        addr_ovf_d = addr_ovf_q;
        if (inst_acc) begin
            inst_cnt_d = sat_inc(inst_cnt_q);
        end
        if (wgt_acc) begin
            wgt_cnt_d = sat_inc(wgt_cnt_q);
        end
        // Wrap counts only if the packet continues past the top address.
        if (wgt_acc && (waddr_q == '1) && !wgt_last) begin
            addr_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_cnt_q <= '0;
            wgt_cnt_q  <= '0;
            addr_ovf_q <= 1'b0;
        end else begin
            inst_cnt_q <= inst_cnt_d;
            wgt_cnt_q  <= wgt_cnt_d;
            addr_ovf_q <= addr_ovf_d;
        end
    end

    assign inst_count = inst_cnt_q;
    assign wgt_count  = wgt_cnt_q;
    assign addr_ovf   = addr_ovf_q;
`else
    assign inst_count = '0;
    assign wgt_count  = '0;
    assign addr_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_config_loader.sv
// -----------------------------------------------------------------------------
// Testbench for mvm_config_loader: directed packets with hand-built expected
// flits, round-robin order, back-pressure, address wrap and async reset.
// -----------------------------------------------------------------------------
module tb_mvm_config_loader;

    localparam int DATAW = 512;
    localparam int USERW = 75;
    localparam int DESTW = 4;
    localparam int IDW   = 2;
    localparam int DPES  = 64;
    localparam int ADDRW = 9;
    localparam int DPEW  = $clog2(DPES);
    localparam int FW    = DATAW + USERW;
    localparam int CW    = 600;

`ifdef MVM_LOADER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [CW-1:0] cv_t;
    typedef struct packed {
        logic [FW-1:0]    data;
        logic [IDW-1:0]   tid;
        logic [DESTW-1:0] dest;
        logic             last;
    } flit_t;

    logic                clk;
    logic                rst_n;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst_data;
    logic [DESTW-1:0]    inst_dest;
    logic                inst_last;
    logic                wgt_valid;
    logic                wgt_ready;
    logic [DATAW-1:0]    wgt_data;
    logic [DPEW-1:0]     wgt_dpe;
    logic [DESTW-1:0]    wgt_dest;
    logic                wgt_last;
    logic                axis_tx_tvalid;
    logic                axis_tx_tready;
    logic [FW-1:0]       axis_tx_tdata;
    logic [IDW-1:0]      axis_tx_tid;
    logic [DESTW-1:0]    axis_tx_tdest;
    logic                axis_tx_tlast;
    logic                busy;
    logic                addr_ovf;
    logic [15:0]         inst_count;
    logic [15:0]         wgt_count;

    int    n_total = 0;
    int    n_bad   = 0;
    int    cyc     = 0;
    int    first_vld = -1;
    flit_t mq[$];
    flit_t eq[$];

    mvm_config_loader #(
        .DATAW(DATAW), .USERW(USERW), .DESTW(DESTW),
        .IDW(IDW), .DPES(DPES), .ADDRW(ADDRW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_dest      (inst_dest),
        .inst_last      (inst_last),
        .wgt_valid      (wgt_valid),
        .wgt_ready      (wgt_ready),
        .wgt_data       (wgt_data),
        .wgt_dpe        (wgt_dpe),
        .wgt_dest       (wgt_dest),
        .wgt_last       (wgt_last),
        .axis_tx_tvalid (axis_tx_tvalid),
        .axis_tx_tready (axis_tx_tready),
        .axis_tx_tdata  (axis_tx_tdata),
        .axis_tx_tid    (axis_tx_tid),
        .axis_tx_tdest  (axis_tx_tdest),
        .axis_tx_tlast  (axis_tx_tlast),
        .busy           (busy),
        .addr_ovf       (addr_ovf),
        .inst_count     (inst_count),
        .wgt_count      (wgt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a flit is transferred on the posedge following a
    // negedge where tvalid and tready are both high.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && axis_tx_tvalid && axis_tx_tready)
                mq.push_back({axis_tx_tdata, axis_tx_tid, axis_tx_tdest, axis_tx_tlast});
            if (rst_n && axis_tx_tvalid && first_vld < 0)
                first_vld = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input cv_t got, input cv_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] iflit(input logic [31:0] w);
        logic [FW-1:0] f;
        f = '0;
        f[31:0] = w;
        return f;
    endfunction

    function automatic logic [FW-1:0] wflit(input int addr, input int dpe,
                                            input logic [DATAW-1:0] d);
        logic [USERW-1:0] u;
        u = '0;
        u[ADDRW-1:0] = addr[ADDRW-1:0];
        u[10:9]      = 2'b11;
        u[11+dpe]    = 1'b1;
        return {u, d};
    endfunction

    task automatic drive_inst(input int n, input logic [DESTW-1:0] dest,
                              input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            logic [31:0] w;
            w = base + 32'(i);
            inst_valid = 1'b1;
            inst_data  = w;
            inst_dest  = dest;
            inst_last  = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!inst_ready && t < 2000);
            if (!inst_ready) begin
                check("inst_accept_timeout", cv_t'(inst_ready), cv_t'(1'b1));
                break;
            end
            eq.push_back({iflit(w), IDW'(0), dest, (i == n - 1)});
            @(posedge clk);
            #1;
        end
        inst_valid = 1'b0;
        inst_last  = 1'b0;
    endtask

    task automatic drive_wgt(input int n, input int dpe, input logic [DESTW-1:0] dest,
                             input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            logic [31:0] w;
            logic [DATAW-1:0] row;
            w   = base + 32'(i);
            row = {16{w}};
            wgt_valid = 1'b1;
            wgt_data  = row;
            wgt_dpe   = dpe[DPEW-1:0];
            wgt_dest  = dest;
            wgt_last  = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!wgt_ready && t < 2000);
            if (!wgt_ready) begin
                check("wgt_accept_timeout", cv_t'(wgt_ready), cv_t'(1'b1));
                break;
            end
            eq.push_back({wflit(i % 512, dpe, row), IDW'(1), dest, (i == n - 1)});
            @(posedge clk);
            #1;
        end
        wgt_valid = 1'b0;
        wgt_last  = 1'b0;
    endtask

    task automatic drain_check(input string tag, input int exp_n);
        check({tag, "_nflits"}, cv_t'(mq.size()), cv_t'(exp_n));
        for (int i = 0; i < eq.size() && i < mq.size(); i++)
            check($sformatf("%s_flit%0d", tag, i), cv_t'(mq[i]), cv_t'(eq[i]));
        mq.delete();
        eq.delete();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_last  = 1'b0;
        wgt_valid  = 1'b0;
        wgt_last   = 1'b0;
        axis_tx_tready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        eq.delete();
    endtask

    initial begin
        int c0;
        int exp_tid[8];
        logic [FW-1:0] held;
        logic          held_last;

        rst_n          = 1'b0;
        inst_valid     = 1'b0;
        inst_data      = '0;
        inst_dest      = '0;
        inst_last      = 1'b0;
        wgt_valid      = 1'b0;
        wgt_data       = '0;
        wgt_dpe        = '0;
        wgt_dest       = '0;
        wgt_last       = 1'b0;
        axis_tx_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid",   cv_t'(axis_tx_tvalid), cv_t'(0));
        check("rst_tdata",    cv_t'(axis_tx_tdata),  cv_t'(0));
        check("rst_tlast",    cv_t'(axis_tx_tlast),  cv_t'(0));
        check("rst_tid",      cv_t'(axis_tx_tid),    cv_t'(0));
        check("rst_tdest",    cv_t'(axis_tx_tdest),  cv_t'(0));
        check("rst_busy",     cv_t'(busy),           cv_t'(0));
        check("rst_addr_ovf", cv_t'(addr_ovf),       cv_t'(0));
        check("rst_inst_cnt", cv_t'(inst_count),     cv_t'(0));
        check("rst_wgt_cnt",  cv_t'(wgt_count),      cv_t'(0));
        check("rst_inst_rdy", cv_t'(inst_ready),     cv_t'(0));
        check("rst_wgt_rdy",  cv_t'(wgt_ready),      cv_t'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 3-word instruction packet to dest 5
        first_vld = -1;
        c0 = cyc;
        drive_inst(3, 4'd5, 32'h1000_0000);
        repeat (3) @(posedge clk);
        #1;
        check("inst_latency", cv_t'(first_vld - c0), cv_t'(2));
        check("inst_count3",  cv_t'(inst_count), cv_t'(STATS ? 16'd3 : 16'd0));
        if (mq.size() == 3) begin
            check("inst_last0", cv_t'(mq[0].last), cv_t'(0));
            check("inst_last2", cv_t'(mq[2].last), cv_t'(1));
            check("inst_tuser", cv_t'(mq[1].data[FW-1:DATAW]), cv_t'(0));
        end
        drain_check("inst", 3);

        // 4-row weight packet, dpe 7, dest 14
        drive_wgt(4, 7, 4'd14, 32'hA5A5_0000);
        repeat (3) @(posedge clk);
        #1;
        check("wgt_count4", cv_t'(wgt_count), cv_t'(STATS ? 16'd4 : 16'd0));
        if (mq.size() == 4) begin
            check("wgt_tuser2", cv_t'(mq[2].data[FW-1:DATAW]),
                  cv_t'((75'd1 << 18) | (75'd3 << 9) | 75'd2));
            check("wgt_tid0", cv_t'(mq[0].tid), cv_t'(1));
        end
        drain_check("wgt", 4);

        // Both requesters with two packets each: I, W, I, W
        do_reset();
        fork
            begin
                drive_inst(2, 4'd3, 32'h2000_0000);
                drive_inst(2, 4'd3, 32'h2100_0000);
            end
            begin
                drive_wgt(2, 1, 4'd9, 32'h3000_0000);
                drive_wgt(2, 1, 4'd9, 32'h3100_0000);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        exp_tid = '{0, 0, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 8; i++)
            if (i < mq.size())
                check($sformatf("rr_tid%0d", i), cv_t'(mq[i].tid), cv_t'(exp_tid[i]));
        drain_check("rr", 8);

        // Back-pressure for 5 cycles in the middle of a weight packet
        do_reset();
        fork
            drive_wgt(6, 3, 4'd2, 32'h4000_0000);
            begin
                for (int t = 0; t < 100 && mq.size() < 2; t++) @(negedge clk);
                @(posedge clk);
                #1;
                axis_tx_tready = 1'b0;
                held      = '0;
                held_last = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        held      = axis_tx_tdata;
                        held_last = axis_tx_tlast;
                    end
                    check($sformatf("stall_tvalid%0d", k), cv_t'(axis_tx_tvalid), cv_t'(1));
                    check($sformatf("stall_tdata%0d", k),  cv_t'(axis_tx_tdata),  cv_t'(held));
                    check($sformatf("stall_tlast%0d", k),  cv_t'(axis_tx_tlast),  cv_t'(held_last));
                    check($sformatf("stall_wrdy%0d", k),   cv_t'(wgt_ready),      cv_t'(0));
                end
                @(posedge clk);
                #1;
                axis_tx_tready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        drain_check("stall", 6);

        // 513-row packet: address wraps 511 -> 0
        do_reset();
        check("ovf_before", cv_t'(addr_ovf), cv_t'(0));
        drive_wgt(513, 0, 4'd1, 32'h5000_0000);
        repeat (3) @(posedge clk);
        #1;
        if (mq.size() == 513) begin
            check("wrap_addr511", cv_t'(mq[511].data[DATAW +: ADDRW]), cv_t'(511));
            check("wrap_addr512", cv_t'(mq[512].data[DATAW +: ADDRW]), cv_t'(0));
        end
        check("ovf_after",   cv_t'(addr_ovf),  cv_t'(STATS ? 1'b1 : 1'b0));
        check("wgt_count513", cv_t'(wgt_count), cv_t'(STATS ? 16'd513 : 16'd0));
        drain_check("wrap", 513);

        // Async reset while a flit is held with tready low
        do_reset();
        axis_tx_tready = 1'b0;
        wgt_valid = 1'b1;
        wgt_data  = {16{32'h7777_0000}};
        wgt_dpe   = '0;
        wgt_dest  = 4'd4;
        wgt_last  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hold_tvalid", cv_t'(axis_tx_tvalid), cv_t'(1));
        check("hold_wrdy",   cv_t'(wgt_ready),      cv_t'(0));
        check("hold_wcnt",   cv_t'(wgt_count),      cv_t'(STATS ? 16'd1 : 16'd0));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", cv_t'(axis_tx_tvalid), cv_t'(0));
        check("arst_tdata",  cv_t'(axis_tx_tdata),  cv_t'(0));
        check("arst_busy",   cv_t'(busy),           cv_t'(0));
        check("arst_wcnt",   cv_t'(wgt_count),      cv_t'(0));
        check("arst_icnt",   cv_t'(inst_count),     cv_t'(0));
        wgt_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        axis_tx_tready = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        eq.delete();
        drive_inst(1, 4'd6, 32'h6000_0001);
        repeat (3) @(posedge clk);
        #1;
        drain_check("post_rst", 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mvm_config_loader.md
Name: mvm_config_loader

Overview:
- Single NoC injection point that sequences MVM configuration traffic (instruction words and weight-RF rows) onto one AXI-S mesh port.
- Arbitrates round-robin, at packet granularity, between an instruction requester and a weight requester.
- Formats each flit as {tuser, data}.
- Sits at the loader node in front of axis_mesh.

Parameters:
- DATAW, 512, tdata bits excluding tuser
- USERW, 75, tuser bits appended above tdata
- DESTW, 4, tdest width
- IDW, 2, tid width
- DPES, 64, number of dot-product engines (rf_en width); 11+DPES must equal USERW
- ADDRW, 9, RF address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  instruction request valid
- inst_ready  out  1  instruction accepted when valid&ready
- inst_data  in  32  instruction word
- inst_dest  in  DESTW  target MVM node
- inst_last  in  1  last instruction of packet
- wgt_valid  in  1  weight row valid
- wgt_ready  out  1  weight row accepted
- wgt_data  in  DATAW  weight row
- wgt_dpe  in  $clog2(DPES)  target DPE index
- wgt_dest  in  DESTW  target MVM node
- wgt_last  in  1  last row of packet
- axis_tx_tvalid  out  1  NoC flit valid
- axis_tx_tready  in  1  NoC ready
- axis_tx_tdata  out  DATAW+USERW  {tuser, data}
- axis_tx_tid  out  IDW  0 = instruction, 1 = weight
- axis_tx_tdest  out  DESTW  destination
- axis_tx_tlast  out  1  packet end
- busy  out  1  FSM not IDLE or output register full
- addr_ovf  out  1  sticky: weight address wrapped within a packet
- inst_count  out  16  accepted instruction flits
- wgt_count  out  16  accepted weight flits

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, rr_last=WGT, output register empty. All outputs 0, including tvalid, tdata, tlast, addr_ovf and both counts. Reset mid-packet drops the held flit and the lock.
- FSM states: IDLE, INST, WGT.
- IDLE:
  - Only inst_valid set -> INST.
  - Only wgt_valid set -> WGT.
  - Both set -> the requester not equal to rr_last.
  - Neither -> stay IDLE.
  - inst_ready and wgt_ready are 0 in IDLE, so each grant costs one bubble cycle.
- INST/WGT:
  - Granted requester's ready = out_can_load, where out_can_load = !out_valid || axis_tx_tready. Other requester's ready = 0.
  - On an accepted flit with last=1: rr_last = current requester, next state IDLE.
  - Lock holds until last. The other requester is starved for the whole packet.
- Output register: single entry, loaded on an accepted request; 1-cycle latency from acceptance to tvalid. Holds stable while tvalid&!tready. Back-to-back throughput is 1 flit/cycle within a packet.
- Instruction flit:
  - tdata[31:0] = inst_data; tdata[DATAW-1:32] = 0
  - tuser = 0 (type 2'b00)
  - tid = 0, tdest = inst_dest, tlast = inst_last
- Weight flit:
  - tdata[DATAW-1:0] = wgt_data
  - tuser[ADDRW-1:0] = waddr
  - tuser[10:9] = 2'b11
  - tuser[11+DPES-1:11] = one-hot(wgt_dpe)
  - tid = 1, tdest = wgt_dest, tlast = wgt_last
- waddr:
  - Cleared to 0 on entry to WGT; increments on each accepted weight flit.
  - Wraps 2^ADDRW-1 -> 0. A wrap inside a packet sets addr_ovf, which is cleared only by reset.
- Counters: increment on each accepted flit of their type; saturate at 0xFFFF.
- Dest/dpe are sampled per flit and may legally change mid-packet.
- A requester dropping valid mid-packet keeps the lock; there is no timeout.

Optional Feature:
- Macro MVM_LOADER_STATS_EN.
- Defined: inst_count, wgt_count and addr_ovf are live as above.
- Undefined: no counter or overflow registers are built; the three ports are tied to 0. Arbitration and datapath are unchanged.

Test Plan:
- Reset then a single 3-word instruction packet to dest 5 (tready=1) -> 3 flits, tid=0, tuser=0, tlast only on the 3rd; inst_count=3; first tvalid 2 cycles after inst_valid rises.
- Weight packet of 4 rows, dpe=7, dest 14 -> tuser addr 0,1,2,3; tuser[10:9]=3; rf_en=1<<7; tid=1; tlast on row 3; wgt_count=4.
- Both requesters valid from IDLE after reset -> INST granted first (rr_last=WGT), WGT packet follows after INST's last; repeat -> order alternates.
- tready held low 5 cycles mid weight packet -> tdata/tlast stable, wgt_ready=0, no flit lost or duplicated, addresses contiguous.
- 513-row weight packet (ADDRW=9) -> address sequence 0..511 then 0; addr_ovf=1 after row 512; with MVM_LOADER_STATS_EN undefined, addr_ovf stays 0.
- rst_n asserted while a flit is held with tready=0 -> tvalid=0 immediately (async), FSM IDLE, counters 0.
